// File: rtl/program_counter.sv
// program_counter: 16-bit PC for the single-cycle CPU datapath.
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset, loads RESET_ADDR
//   pc_en       - update enable, 0 holds addr (stall)
//   jump_or_not - 1 = addr + ext, 0 = addr + INC
//   ext         - sign-extended two's-complement offset
//   addr        - registered PC / instruction-memory address
module program_counter #(
  parameter int unsigned       WIDTH      = 16,
  parameter logic [WIDTH-1:0]  RESET_ADDR = '0,
  parameter int unsigned       INC        = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_en,
  input  logic             jump_or_not,
  input  logic [WIDTH-1:0] ext,
  output logic [WIDTH-1:0] addr
);

  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] addr_nxt;

  // Unsigned WIDTH-bit add gives two's-complement relative jumps;
  // carry out is dropped so both directions wrap silently.
  always_comb begin
    step     = jump_or_not ? ext : WIDTH'(INC);
    addr_nxt = addr + step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= RESET_ADDR;
    end else if (pc_en) begin
      addr <= addr_nxt;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

  logic        clk;
  logic        rst_n;
  logic        pc_en;
  logic        jump_or_not;
  logic [15:0] ext;
  logic [15:0] addr;

  int unsigned checks;
  int unsigned failures;

  program_counter #(
    .WIDTH      (16),
    .RESET_ADDR (16'h0000),
    .INC        (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_en       (pc_en),
    .jump_or_not (jump_or_not),
    .ext         (ext),
    .addr        (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: addr=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, check at the next negedge.
  task automatic step(input logic pe, input logic j, input logic [15:0] e,
                      input logic [15:0] exp, input string tag);
    pc_en       = pe;
    jump_or_not = j;
    ext         = e;
    @(negedge clk);
    check(tag, addr, exp);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    pc_en       = 1'b1;
    jump_or_not = 1'b1;
    ext         = 16'h1234;

    // Reset held for two clocks with active inputs
    #1 check("reset_async", addr, 16'h0000);
    @(negedge clk); check("reset_hold1", addr, 16'h0000);
    @(negedge clk); check("reset_hold2", addr, 16'h0000);

    // Release with pc_en=0, then sequential advance
    rst_n = 1'b1;
    step(1'b0, 1'b0, 16'h0000, 16'h0000, "release_hold");
    step(1'b1, 1'b0, 16'h0000, 16'h0001, "seq1");
    step(1'b1, 1'b0, 16'h0000, 16'h0002, "seq2");
    step(1'b1, 1'b0, 16'h0000, 16'h0003, "seq3");

    // Back to 0002, then forward jump, then sequential with ext ignored
    step(1'b1, 1'b1, 16'hFFFF, 16'h0002, "jump_back1");
    step(1'b1, 1'b1, 16'hAAAA, 16'hAAAC, "jump_aaaa");
    step(1'b1, 1'b0, 16'h0100, 16'hAAAD, "seq_ext_ignored");

    // To 0010, then -16 lands on 0000
    step(1'b1, 1'b1, 16'h5563, 16'h0010, "jump_to_0010");
    step(1'b1, 1'b1, 16'hFFF0, 16'h0000, "jump_neg16");

    // Wrap of sequential advance at FFFF
    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, "jump_to_ffff");
    step(1'b1, 1'b0, 16'h0000, 16'h0000, "seq_wrap");

    // ext=0 re-executes the same address
    step(1'b1, 1'b1, 16'h0000, 16'h0000, "jump_zero");

    // Stall at 0042 with jump inputs active
    step(1'b1, 1'b1, 16'h0042, 16'h0042, "jump_to_0042");
    step(1'b0, 1'b1, 16'h0005, 16'h0042, "stall1");
    step(1'b0, 1'b1, 16'h0005, 16'h0042, "stall2");
    step(1'b0, 1'b1, 16'h0005, 16'h0042, "stall3");

    // Mid-cycle asynchronous reset while enabled
    pc_en       = 1'b1;
    jump_or_not = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("midcycle_reset", addr, 16'h0000);
    @(negedge clk); check("midcycle_reset_hold", addr, 16'h0000);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h0000, 16'h0001, "resume1");
    step(1'b1, 1'b0, 16'h0000, 16'h0002, "resume2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 16-bit program counter for the single-cycle CPU datapath; drives the instruction-memory address.
- Each enabled clock it either advances by one instruction word, or takes a PC-relative jump/branch using the sign-extended immediate `ext` from the decode stage.
- Holds its value when not enabled (stall).

Parameters:
- WIDTH, 16, address/immediate width in bits.
- RESET_ADDR, 16'h0000, value loaded into `addr` on reset.
- INC, 1, step added on a sequential (non-jump) advance.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_en  input  1  update enable; 0 = hold `addr` (stall).
- jump_or_not  input  1  1 = take relative jump this cycle; 0 = sequential advance.
- ext  input  WIDTH  sign-extended immediate offset (two's complement); used only when jump_or_not=1.
- addr  output  WIDTH  current PC; registered output; instruction-memory address.

Behaviour:
- Reset:
  - rst_n=0 asynchronously forces `addr` = RESET_ADDR, immediately and independent of clk.
  - `addr` holds RESET_ADDR for as long as rst_n=0; all other inputs are ignored.
  - Reset asserted mid-operation overrides any pending update.
- Release: first rising edge with rst_n=1 performs a normal update per the rules below.
- Update rules, on each rising clk edge with rst_n=1 (priority top-down):
  - pc_en=0: addr <= addr (hold), regardless of jump_or_not/ext.
  - pc_en=1, jump_or_not=1: addr <= addr + ext, modulo 2^WIDTH.
    - `ext` is two's complement, so negative offsets jump backwards.
    - ext=0 re-executes the same address.
  - pc_en=1, jump_or_not=0: addr <= addr + INC, modulo 2^WIDTH.
- Latency: the new `addr` is visible one clock after the inputs are sampled. There is no combinational path from any input to `addr` except the asynchronous reset.
- Arithmetic:
  - WIDTH-bit add; carry out discarded.
  - Wrap-around is silent: 16'hFFFF + 1 = 16'h0000; 16'h0002 + 16'hFFFE = 16'h0000.
  - No overflow flag.
- `ext` and `jump_or_not` are don't-care whenever pc_en=0 or rst_n=0.
- No X propagation out of reset: `addr` is defined from the first reset assertion.

Test Plan:
- Hold rst_n=0 for 2 clocks with pc_en=1, jump_or_not=1, ext=16'h1234 -> addr stays 16'h0000 throughout.
- Release reset with pc_en=0 for 1 clock, then pc_en=1, jump_or_not=0 for 3 clocks -> addr 0000, 0000, 0001, 0002, 0003.
- From addr=16'h0002: jump_or_not=1, ext=16'hAAAA for 1 clock -> addr=16'hAAAC; next clock with jump_or_not=0, ext=16'h0100 -> addr=16'hAAAD (ext ignored).
- From addr=16'h0010: jump_or_not=1, ext=16'hFFF0 (-16) -> addr=16'h0000. Separately, sequential advance from addr=16'hFFFF -> addr=16'h0000 (wrap).
- Stall: pc_en=0 with jump_or_not=1, ext=16'h0005 for 3 clocks -> addr unchanged.
- Assert rst_n=0 between clock edges while addr=16'h0042 -> addr=16'h0000 immediately, before the next edge; after release, counting resumes from 0000.
